axi4_lite_master_read: RTL and testbench

- AXI4-Lite read master that fetches one cache block from external memory as a sequence of single-beat reads.
- Sits between the cache/memory-unit miss logic and the AXI4-Lite slave read port; it drives AR, sinks R.
- AXI4-Lite has no bursts, so the block issues BEATS = BLOCK_WIDTH/AXI_DATA_WIDTH sequential address/data handshakes, assembles the block, then reports completion and any error.

---
 rtl/axi4_lite_master_read.sv | 125 ++++++++++++
 tb/tb_axi4_lite_master_read.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_master_read.sv
// AXI4-Lite read master: fetches one cache block as a series of single-beat
// reads, assembles it, then pulses completion with a sticky error flag.
module axi4_lite_master_read #(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32,
   parameter int BLOCK_WIDTH    = 512
) (
   input  logic                      clk_i,
   input  logic                      arst_i,
   input  logic                      read_request_i,
   input  logic [AXI_ADDR_WIDTH-1:0] addr_i,
   output logic [BLOCK_WIDTH-1:0]    block_o,
   output logic                      read_done_o,
   output logic                      read_error_o,
   output logic                      busy_o,
   output logic                      AR_VALID,
   output logic [AXI_ADDR_WIDTH-1:0] AR_ADDR,
   output logic [2:0]                AR_PROT,
   input  logic                      AR_READY,
   output logic                      R_READY,
   input  logic [AXI_DATA_WIDTH-1:0] R_DATA,
   input  logic [1:0]                R_RESP,
   input  logic                      R_VALID
);

   localparam int BEATS = BLOCK_WIDTH / AXI_DATA_WIDTH;
   localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BOFF  = $clog2(BLOCK_WIDTH / 8);
   localparam int DOFF  = $clog2(AXI_DATA_WIDTH / 8);

   localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] BASE_MASK =
      ~((AXI_ADDR_WIDTH'(1) << BOFF) - AXI_ADDR_WIDTH'(1));

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA,
      DONE
   } state_t;

   state_t                    state_q;
   state_t                    state_d;
   logic [CW-1:0]             beat_q;
   logic                      err_q;
   logic [AXI_ADDR_WIDTH-1:0] base_q;
   logic [BLOCK_WIDTH-1:0]    block_q;
   logic                      start;
   logic                      r_hs;

   assign start = (state_q == IDLE) && read_request_i;
   assign r_hs  = (state_q == DATA) && R_VALID;

   // State register; reset aborts any fetch in flight.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: one AR then one R handshake per beat.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (read_request_i) begin
               state_d = ADDR;
            end
         end
         ADDR: begin
            if (AR_READY) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (R_VALID) begin
               state_d = (beat_q == LAST) ? DONE : ADDR;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath: block base, beat index, assembled data, sticky error.
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         base_q  <= '0;
         beat_q  <= '0;
         err_q   <= 1'b0;
         block_q <= '0;
      end else begin
         if (start) begin
            base_q <= addr_i & BASE_MASK;
            beat_q <= '0;
            err_q  <= 1'b0;
         end
         if (r_hs) begin
            block_q[int'(beat_q)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= R_DATA;
            if (R_RESP != 2'b00) begin
               err_q <= 1'b1;
            end
            if (beat_q != LAST) begin
               beat_q <= beat_q + CW'(1);
            end
         end
      end
   end

   assign AR_VALID     = (state_q == ADDR);
   assign R_READY      = (state_q == DATA);
   assign read_done_o  = (state_q == DONE);
   assign read_error_o = (state_q == DONE) && err_q;
   assign busy_o       = (state_q != IDLE);
   assign AR_ADDR      = base_q + (AXI_ADDR_WIDTH'(beat_q) << DOFF);
   assign AR_PROT      = 3'b000;
   assign block_o      = block_q;

endmodule

// File: tb/tb_axi4_lite_master_read.sv
// Bench for axi4_lite_master_read: directed fetches against a
// scripted AXI4-Lite slave with a scoreboard of addresses and blocks.
module tb_axi4_lite_master_read;

   logic         clk_i;
   logic         arst_i;
   logic         read_request_i;
   logic [63:0]  addr_i;
   logic [511:0] block_o;
   logic         read_done_o;
   logic         read_error_o;
   logic         busy_o;
   logic         AR_VALID;
   logic [63:0]  AR_ADDR;
   logic [2:0]   AR_PROT;
   logic         AR_READY;
   logic         R_READY;
   logic [31:0]  R_DATA;
   logic [1:0]   R_RESP;
   logic         R_VALID;

   axi4_lite_master_read dut (
      .clk_i          (clk_i),
      .arst_i         (arst_i),
      .read_request_i (read_request_i),
      .addr_i         (addr_i),
      .block_o        (block_o),
      .read_done_o    (read_done_o),
      .read_error_o   (read_error_o),
      .busy_o         (busy_o),
      .AR_VALID       (AR_VALID),
      .AR_ADDR        (AR_ADDR),
      .AR_PROT        (AR_PROT),
      .AR_READY       (AR_READY),
      .R_READY        (R_READY),
      .R_DATA         (R_DATA),
      .R_RESP         (R_RESP),
      .R_VALID        (R_VALID)
   );

   int vecs = 0;
   int errs = 0;
   int cyc  = 0;

   int  ar_delay [16];
   int  r_delay  [16];
   int  err_beat = -1;
   bit  rv_early = 0;
   int  ar_idx = 0;
   int  r_idx  = 0;
   int  ar_wait = 0;
   int  r_wait  = 0;
   int  nhs = 0;

   logic [31:0]  pend     [$];
   logic [63:0]  exp_addr [$];
   logic [511:0] exp_blk  [$];
   logic         exp_err  [$];

   bit           done_seen = 0;
   bit           prev_done = 0;
   int           done_cyc  = 0;
   logic [511:0] got_blk;
   logic         got_err;
   logic [511:0] dummy_blk;
   logic         dummy_err;

   task automatic chk(input string tag, input logic [511:0] obs,
                      input logic [511:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      forever begin
         @(posedge clk_i);
         cyc++;
      end
   end

   // Scripted slave and output monitor, acting on the falling edge.
   initial begin
      AR_READY = 1'b0;
      R_VALID  = 1'b0;
      R_DATA   = '0;
      R_RESP   = 2'b00;
      forever begin
         @(negedge clk_i);
         if (arst_i) begin
            AR_READY = 1'b0;
            R_VALID  = 1'b0;
            pend.delete();
            ar_idx = 0;
            r_idx  = 0;
            ar_wait = 0;
            r_wait  = 0;
            prev_done = 1'b0;
         end else begin
            if (AR_VALID) begin
               if (ar_wait < ar_delay[ar_idx % 16]) begin
                  AR_READY = 1'b0;
                  ar_wait++;
                  if (exp_addr.size() > 0) chk("ar_hold", AR_ADDR, exp_addr[0]);
               end else begin
                  AR_READY = 1'b1;
                  ar_wait = 0;
                  if (exp_addr.size() > 0) chk("ar_addr", AR_ADDR, exp_addr.pop_front());
                  pend.push_back(AR_ADDR[31:0]);
                  ar_idx++;
                  nhs++;
               end
            end else begin
               AR_READY = 1'b0;
            end
            if (R_READY && pend.size() > 0) begin
               if (r_wait < r_delay[r_idx % 16]) begin
                  R_VALID = 1'b0;
                  r_wait++;
               end else begin
                  R_VALID = 1'b1;
                  R_DATA  = pend.pop_front();
                  R_RESP  = (r_idx == err_beat) ? 2'b10 : 2'b00;
                  r_idx++;
                  r_wait = 0;
               end
            end else if (rv_early && AR_VALID) begin
               R_VALID = 1'b1;
               R_DATA  = 32'hDEAD_BEEF;
               R_RESP  = 2'b00;
               chk("rready_in_addr", R_READY, 1'b0);
            end else begin
               R_VALID = 1'b0;
            end
            if (read_done_o) begin
               chk("done_twice", prev_done, 1'b0);
               done_seen = 1'b1;
               done_cyc  = cyc;
               got_blk   = block_o;
               got_err   = read_error_o;
            end
            prev_done = read_done_o;
         end
      end
   end

   task automatic clr_knobs();
      for (int i = 0; i < 16; i++) begin
         ar_delay[i] = 0;
         r_delay[i]  = 0;
      end
      err_beat = -1;
      rv_early = 1'b0;
   endtask

   task automatic push_exp(input logic [63:0] a, input logic e);
      logic [63:0]  base;
      logic [511:0] blk;
      base = a & ~64'h3F;
      blk  = '0;
      for (int i = 0; i < 16; i++) begin
         exp_addr.push_back(base + 64'(4 * i));
         blk[i*32 +: 32] = base[31:0] + 32'(4 * i);
      end
      exp_blk.push_back(blk);
      exp_err.push_back(e);
   endtask

   task automatic start(input logic [63:0] a, input logic e, output int c0);
      @(negedge clk_i);
      #1;
      c0 = cyc;
      push_exp(a, e);
      read_request_i = 1'b1;
      addr_i = a;
      @(negedge clk_i);
      #1;
      read_request_i = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int c0, input int lat);
      for (int i = 0; i < 300 && !done_seen; i++) begin
         @(negedge clk_i);
         #1;
      end
      chk({tag, "_done_seen"}, done_seen, 1'b1);
      chk({tag, "_latency"}, done_cyc - c0, lat);
      chk({tag, "_block"}, got_blk, exp_blk.pop_front());
      chk({tag, "_error"}, got_err, exp_err.pop_front());
      chk({tag, "_ar_count"}, nhs, 16);
      done_seen = 1'b0;
      nhs = 0;
      ar_idx = 0;
      r_idx = 0;
   endtask

   initial begin
      int c0;
      arst_i = 1'b1;
      read_request_i = 1'b0;
      addr_i = '0;
      clr_knobs();
      @(negedge clk_i);
      #1;
      chk("rst_block", block_o, '0);
      chk("rst_outs", {read_done_o, read_error_o, AR_VALID, R_READY, busy_o}, 5'b0);
      chk("rst_araddr", AR_ADDR, '0);
      chk("arprot", AR_PROT, 3'b000);
      @(negedge clk_i);
      #1;
      arst_i = 1'b0;

      // 1: zero-wait fetch
      start(64'h1000_0044, 1'b0, c0);
      wait_done("t1", c0, 33);
      chk("t1_lo", got_blk[31:0], 32'h1000_0040);
      chk("t1_hi", got_blk[511:480], 32'h1000_007C);

      // 2: AR wait on beat 0, R wait on beat 9
      clr_knobs();
      ar_delay[0] = 3;
      r_delay[9]  = 2;
      start(64'h1000_0044, 1'b0, c0);
      wait_done("t2", c0, 38);

      // 3: error on beat 5, then a clean fetch
      clr_knobs();
      err_beat = 5;
      start(64'h1000_0100, 1'b1, c0);
      wait_done("t3e", c0, 33);
      clr_knobs();
      start(64'h1000_0100, 1'b0, c0);
      wait_done("t3c", c0, 33);

      // 4: reset during DATA of beat 7
      clr_knobs();
      r_delay[7] = 20;
      start(64'h1000_0000, 1'b0, c0);
      for (int i = 0; i < 200 && !(ar_idx == 8 && R_READY); i++) begin
         @(negedge clk_i);
         #1;
      end
      chk("t4_in_data", R_READY, 1'b1);
      arst_i = 1'b1;
      #1;
      chk("t4_async", {AR_VALID, R_READY, busy_o}, 3'b000);
      chk("t4_block", block_o, '0);
      @(negedge clk_i);
      #1;
      arst_i = 1'b0;
      exp_addr.delete();
      dummy_blk = exp_blk.pop_front();
      dummy_err = exp_err.pop_front();
      done_seen = 1'b0;
      nhs = 0;
      clr_knobs();
      start(64'h2000_0000, 1'b0, c0);
      wait_done("t4", c0, 33);

      // 5: request held high across the whole fetch and DONE
      @(negedge clk_i);
      #1;
      c0 = cyc;
      push_exp(64'h1000_0200, 1'b0);
      read_request_i = 1'b1;
      addr_i = 64'h1000_0200;
      wait_done("t5a", c0, 33);
      @(negedge clk_i);
      #1;
      chk("t5_idle_gap", {AR_VALID, busy_o}, 2'b00);
      c0 = cyc;
      push_exp(64'h1000_0200, 1'b0);
      @(negedge clk_i);
      #1;
      chk("t5_ar_rise", AR_VALID, 1'b1);
      read_request_i = 1'b0;
      wait_done("t5b", c0, 33);

      // 6: R_VALID driven while the master is in ADDR
      clr_knobs();
      rv_early = 1'b1;
      start(64'h1000_0080, 1'b0, c0);
      wait_done("t6", c0, 33);
      clr_knobs();

      repeat (3) @(negedge clk_i);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
